// File: rtl/tone_divider_multi.sv
// tone_divider_multi: multi-channel square-wave tone generator sharing one sequential divider
// that converts Hz to a half-period count; new settings apply only at half-period boundaries.
module tone_divider_multi #(
  parameter int CLK_HZ   = 50000000,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 26,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [31:0]         cfg_freq,
  input  logic                cfg_en,
  output logic [CHANNELS-1:0] tone_out,
  output logic [CHANNELS-1:0] period_tick
);
  localparam logic [32:0] N_MAX = (33'd1 << CNT_W) - 33'd1;
  typedef enum logic [1:0] {IDLE, DIV, WRITE} state_t;
  state_t            state_q;
  logic [CH_W-1:0]   ch_q;
  logic              en_q;
  logic [32:0]       dvs_q;
  logic [32:0]       rem_q;
  logic [31:0]       quo_q;
  logic [4:0]        it_q;
  logic [33:0]       sh_d;
  logic              ge_d;
  logic [CNT_W-1:0]  n_d;
  always_comb begin
    sh_d = {rem_q, quo_q[31]};
    ge_d = sh_d >= {1'b0, dvs_q};
    n_d  = (quo_q == '0) ? CNT_W'(1) :
           ({1'b0, quo_q} > N_MAX) ? N_MAX[CNT_W-1:0] : quo_q[CNT_W-1:0];
  end
  assign cfg_ready = state_q == IDLE;
  // quo_q starts as the dividend and shifts quotient bits in as it shifts dividend bits out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      en_q    <= 1'b0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      it_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (cfg_valid && int'(cfg_ch) < CHANNELS) begin
          ch_q    <= cfg_ch;
          en_q    <= cfg_en && cfg_freq != '0;
          dvs_q   <= {cfg_freq, 1'b0};
          rem_q   <= '0;
          quo_q   <= 32'(CLK_HZ);
          it_q    <= '0;
          state_q <= (cfg_en && cfg_freq != '0) ? DIV : WRITE;
        end
        DIV: begin
          rem_q   <= 33'(ge_d ? sh_d - {1'b0, dvs_q} : sh_d);
          quo_q   <= {quo_q[30:0], ge_d};
          it_q    <= it_q + 5'd1;
          state_q <= (it_q == 5'd31) ? WRITE : DIV;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, n_q, sh_n_q;
    logic             on_q, sh_en_q, pend_q, tone_q, tick_q;
    logic             wr, bnd;
    assign wr  = state_q == WRITE && ch_q == CH_W'(i);
    assign bnd = cnt_q == n_q - CNT_W'(1);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        n_q     <= '0;
        sh_n_q  <= '0;
        on_q    <= 1'b0;
        sh_en_q <= 1'b0;
        pend_q  <= 1'b0;
        tone_q  <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if (on_q && bnd) begin
          cnt_q  <= '0;
          tone_q <= (pend_q && !sh_en_q) ? 1'b0 : ~tone_q;
          tick_q <= !(pend_q && !sh_en_q) && !tone_q;
          if (pend_q) begin
            n_q    <= sh_n_q;
            on_q   <= sh_en_q;
            pend_q <= 1'b0;
          end
        end else if (on_q) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end else if (pend_q) begin
          n_q    <= sh_n_q;
          on_q   <= sh_en_q;
          pend_q <= 1'b0;
          tone_q <= 1'b0;
          cnt_q  <= '0;
        end
        // a write landing on a boundary stays pending for the following boundary
        if (wr) begin
          sh_n_q  <= n_d;
          sh_en_q <= en_q;
          pend_q  <= 1'b1;
        end
      end
    end
    assign tone_out[i]    = tone_q;
    assign period_tick[i] = tick_q;
  end
endmodule

// File: tb/tb_tone_divider_multi.sv
// tb_tone_divider_multi: randomized and directed checks of tone periods, handshake timing,
// boundary-aligned updates and async reset, against expected half-periods from CLK_HZ/(2*freq).
module tb_tone_divider_multi;
  localparam int CLK_HZ = 1000;
  localparam int NCH    = 3;
  localparam int CNT_W  = 8;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [31:0] cfg_freq = '0;
  logic        cfg_en = 1'b0;
  logic [NCH-1:0] tone_out, period_tick;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tog[NCH][$];
  int ticks[NCH][$];
  logic [NCH-1:0] prev_t = '0;

  tone_divider_multi #(.CLK_HZ(CLK_HZ), .CHANNELS(NCH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_freq(cfg_freq), .cfg_en(cfg_en),
    .tone_out(tone_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (tone_out[c] !== prev_t[c]) tog[c].push_back(cyc);
      if (period_tick[c] === 1'b1) ticks[c].push_back(cyc);
    end
    prev_t = tone_out;
  end

  function automatic int model_n(input int f);
    int q;
    q = CLK_HZ / (2 * f);
    return (q == 0) ? 1 : (q > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : q;
  endfunction

  task automatic clear_hist();
    for (int c = 0; c < NCH; c++) begin
      tog[c].delete();
      ticks[c].delete();
    end
  endtask

  task automatic wait_ready(output int w);
    int k = 0;
    while (cfg_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    w = cyc;
    if (k >= 200) begin
      checks++; errors++;
      $display("FAIL ready_timeout: cfg_ready=%b required 1", cfg_ready);
    end
  endtask

  task automatic send(input int c, input int f, input bit e, output int acc);
    int w;
    wait_ready(w);
    cfg_ch = 2'(c); cfg_freq = 32'(f); cfg_en = e; cfg_valid = 1'b1;
    @(negedge clk);
    acc = cyc;
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tone_out !== '0) begin errors++; $display("FAIL reset_tone: got %b required 0", tone_out); end
    checks++; if (period_tick !== '0) begin errors++; $display("FAIL reset_tick: got %b required 0", period_tick); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", cfg_ready); end
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tone_out !== '0 || period_tick !== '0 || cfg_ready !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_after_reset: %0d bad cycles required 0", bad); end
  endtask

  task automatic test_basic();
    int acc, n = 0, bad = 0;
    clear_hist();
    send(0, 100, 1'b1, acc);
    while (cfg_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n != 33) begin errors++; $display("FAIL ready_low_cycles: got %0d required 33", n); end
    repeat (60) @(negedge clk);
    checks++;
    if (tog[0].size() < 5) begin errors++; $display("FAIL basic_toggles: got %0d required >=5", tog[0].size()); end
    else begin
      if (tog[0][0] - acc != 39) begin errors++; $display("FAIL basic_first_toggle: got %0d required 39", tog[0][0] - acc); end
      for (int k = 0; k < 4; k++) if (tog[0][k+1] - tog[0][k] != model_n(100)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL basic_half_period: %0d bad required 0", bad); end
    end
    checks++;
    if (ticks[0].size() < 2 || tog[0].size() < 1) begin errors++; $display("FAIL basic_ticks: got %0d required >=2", ticks[0].size()); end
    else if (ticks[0][1] - ticks[0][0] != 10 || ticks[0][0] != tog[0][0]) begin
      errors++; $display("FAIL basic_tick_spacing: got %0d/%0d required 10/%0d", ticks[0][1] - ticks[0][0], ticks[0][0], tog[0][0]);
    end
  endtask

  task automatic test_independence();
    int acc, w, bad0 = 0, bad1 = 0;
    clear_hist();
    send(1, 250, 1'b1, acc);
    wait_ready(w);
    repeat (40) @(negedge clk);
    for (int k = 0; k + 1 < tog[0].size(); k++) if (tog[0][k+1] - tog[0][k] != 5) bad0++;
    checks++; if (bad0 != 0 || tog[0].size() < 10) begin errors++; $display("FAIL ch0_disturbed: %0d bad of %0d required 0", bad0, tog[0].size()); end
    checks++;
    if (tog[1].size() < 5) begin errors++; $display("FAIL ch1_toggles: got %0d required >=5", tog[1].size()); end
    else begin
      if (tog[1][0] - w != 1 + model_n(250)) begin errors++; $display("FAIL ch1_first_toggle: got %0d required %0d", tog[1][0] - w, 1 + model_n(250)); end
      for (int k = 0; k + 1 < tog[1].size(); k++) if (tog[1][k+1] - tog[1][k] != 2) bad1++;
      checks++; if (bad1 != 0) begin errors++; $display("FAIL ch1_half_period: %0d bad required 0", bad1); end
    end
    send(3, 100, 1'b1, acc);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL bad_ch_ready: got %b required 1", cfg_ready); end
    repeat (40) @(negedge clk);
    checks++; if (tog[2].size() != 0) begin errors++; $display("FAIL bad_ch_drop: ch2 toggles %0d required 0", tog[2].size()); end
  endtask

  task automatic test_glitch_free();
    int acc, w, ip = -1, bad = 0;
    clear_hist();
    send(0, 50, 1'b1, acc);
    wait_ready(w);
    repeat (40) @(negedge clk);
    for (int k = 0; k < tog[0].size(); k++) if (tog[0][k] <= w) ip = k;
    checks++;
    if (ip < 0 || ip + 3 >= tog[0].size()) begin errors++; $display("FAIL glitch_toggles: index %0d of %0d", ip, tog[0].size()); end
    else begin
      if (tog[0][ip+1] - tog[0][ip] != 5) begin errors++; $display("FAIL glitch_old_half: got %0d required 5", tog[0][ip+1] - tog[0][ip]); end
      if (tog[0][ip+2] - tog[0][ip+1] != model_n(50)) bad++;
      if (tog[0][ip+3] - tog[0][ip+2] != model_n(50)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL glitch_new_half: %0d bad required 0", bad); end
    end
    send(0, 0, 1'b1, acc);
    wait_ready(w);
    repeat (12) @(negedge clk);
    checks++; if (tone_out[0] !== 1'b0) begin errors++; $display("FAIL silence_tone: got %b required 0", tone_out[0]); end
    clear_hist();
    repeat (50) @(negedge clk);
    checks++; if (tog[0].size() != 0) begin errors++; $display("FAIL silence_stays: toggles %0d required 0", tog[0].size()); end
  endtask

  task automatic test_clamp();
    int acc, w, bad = 0;
    send(1, 600, 1'b1, acc);
    wait_ready(w);
    repeat (10) @(negedge clk);
    clear_hist();
    repeat (8) @(negedge clk);
    for (int k = 0; k + 1 < tog[1].size(); k++) if (tog[1][k+1] - tog[1][k] != 1) bad++;
    checks++; if (bad != 0 || tog[1].size() < 6) begin errors++; $display("FAIL clamp_low: %0d bad of %0d required 0", bad, tog[1].size()); end
    send(1, 1, 1'b1, acc);
    wait_ready(w);
    repeat (5) @(negedge clk);
    clear_hist();
    repeat (520) @(negedge clk);
    bad = 0;
    for (int k = 0; k + 1 < tog[1].size(); k++) if (tog[1][k+1] - tog[1][k] != 255) bad++;
    checks++; if (bad != 0 || tog[1].size() < 2) begin errors++; $display("FAIL clamp_high: %0d bad of %0d required 0", bad, tog[1].size()); end
    send(1, 100, 1'b0, acc);
    wait_ready(w);
    repeat (260) @(negedge clk);
    checks++; if (tone_out[1] !== 1'b0) begin errors++; $display("FAIL mute_tone: got %b required 0", tone_out[1]); end
    clear_hist();
    repeat (30) @(negedge clk);
    checks++; if (tog[1].size() != 0) begin errors++; $display("FAIL mute_stays: toggles %0d required 0", tog[1].size()); end
  endtask

  task automatic test_random();
    int acc, w, c, f, n, bad;
    bit e;
    for (int it = 0; it < 5; it++) begin
      c = $urandom_range(0, NCH - 1);
      f = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(2, 700);
      e = $urandom_range(0, 4) != 0;
      send(c, f, e, acc);
      wait_ready(w);
      repeat (260) @(negedge clk);
      clear_hist();
      bad = 0;
      if (e && f != 0) begin
        n = model_n(f);
        repeat (3 * n + 3) @(negedge clk);
        for (int k = 0; k + 1 < tog[c].size(); k++) if (tog[c][k+1] - tog[c][k] != n) bad++;
        checks++;
        if (bad != 0 || tog[c].size() < 3) begin
          errors++; $display("FAIL rand_period ch%0d f=%0d: %0d bad of %0d toggles, half %0d", c, f, bad, tog[c].size(), n);
        end
      end else begin
        repeat (60) @(negedge clk);
        checks++;
        if (tone_out[c] !== 1'b0 || tog[c].size() != 0) begin
          errors++; $display("FAIL rand_silent ch%0d: tone %b toggles %0d required 0/0", c, tone_out[c], tog[c].size());
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int acc, w, bad = 0;
    send(2, 250, 1'b1, acc);
    wait_ready(w);
    repeat (10) @(negedge clk);
    send(1, 100, 1'b1, acc);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tone_out !== '0 || period_tick !== '0) begin errors++; $display("FAIL async_outputs: tone %b tick %b required 0", tone_out, period_tick); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL async_ready: got %b required 1", cfg_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_hist();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tone_out !== '0 || cfg_ready !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL async_idle_after: %0d bad cycles required 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_independence();
    test_glitch_free();
    test_clamp();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
